alu_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered ALU (arith/logic/CMP/shift units, one-cycle registered latency, result-valid flag) among NUM_REQ requesters. It accepts one command at a time, drives the ALU operands, function and enable for exactly one cycle, and waits for the ALU's valid flag. It then returns the result to the winning requester, tagged with that requester's ID. A watchdog aborts with an error if the ALU never flags valid.

---
 rtl/alu_req_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU among NUM_REQ requesters.
// One command in flight at a time; a watchdog turns a missing ALU valid into an error response.
`timescale 1ns/1ps
module alu_req_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_A,
  input  logic [NUM_REQ*WIDTH-1:0] req_B,
  input  logic [NUM_REQ*4-1:0]     req_fun,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         ALU_A,
  output logic [WIDTH-1:0]         ALU_B,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  input  logic [WIDTH-1:0]         ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    cur_id;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  int                 idx;

  // Scan from the requester after the last grant, wrapping, first valid wins.
  always_comb begin
    grant   = '0;
    win_id  = '0;
    win_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        win_id     = ID_W'(idx);
        win_any    = 1'b1;
      end
    end
  end

  // Grant is only visible in IDLE and is forced low while reset is held.
  assign req_ready = (state == IDLE && RST) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      wait_cnt   <= '0;
      ALU_A      <= '0;
      ALU_B      <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            ALU_A   <= req_A[int'(win_id)*WIDTH +: WIDTH];
            ALU_B   <= req_B[int'(win_id)*WIDTH +: WIDTH];
            ALU_FUN <= req_fun[int'(win_id)*4 +: 4];
            cur_id  <= win_id;
            ALU_EN  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          ALU_EN   <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A valid on the final permitted cycle still beats the watchdog.
          if (ALU_OUT_VALID) begin
            rsp_data  <= ALU_OUT;
            rsp_err   <= 1'b0;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= cur_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter: transaction-level arbitration model plus a behavioural ALU
// with programmable valid latency (0 = never responds).
`timescale 1ns/1ps
module tb_alu_req_arbiter;
  localparam int WIDTH   = 16;
  localparam int NR      = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NR-1:0]       req_valid;
  logic [NR*WIDTH-1:0] req_A, req_B;
  logic [NR*4-1:0]     req_fun;
  logic [NR-1:0]       req_ready;
  logic [WIDTH-1:0]    ALU_A, ALU_B;
  logic [3:0]          ALU_FUN;
  logic                ALU_EN;
  logic [WIDTH-1:0]    ALU_OUT;
  logic                ALU_OUT_VALID;
  logic                rsp_valid, rsp_ready;
  logic [WIDTH-1:0]    rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] cmd_a [NR];
  logic [WIDTH-1:0] cmd_b [NR];
  logic [3:0]       cmd_f [NR];
  int               ptr_m;
  logic [NR-1:0]    pend;
  int               alu_delay;
  int               last_id;

  alu_req_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NR), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_A(req_A), .req_B(req_B), .req_fun(req_fun), .req_ready(req_ready),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (a == b) ? WIDTH'(1) : WIDTH'(0);
      4'd6:    return a << b[3:0];
      4'd7:    return a >> b[3:0];
      default: return ~a;
    endcase
  endfunction

  // Winner = valid requester at the smallest circular distance past the last grant.
  function automatic int model_pick(input logic [NR-1:0] m);
    int best, bestd, d;
    best  = 0;
    bestd = NR + 1;
    for (int i = 0; i < NR; i++) begin
      d = (i - ptr_m - 1 + 2 * NR) % NR;
      if (m[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic drive_req(input logic [NR-1:0] m);
    req_valid = m;
    for (int i = 0; i < NR; i++) begin
      req_A[i*WIDTH +: WIDTH] = cmd_a[i];
      req_B[i*WIDTH +: WIDTH] = cmd_b[i];
      req_fun[i*4 +: 4]       = cmd_f[i];
    end
  endtask

  // Behavioural registered ALU: valid appears alu_delay cycles into WAIT, junk data otherwise.
  initial begin : alu_model
    int  wcnt;
    bit  armed;
    wcnt = 0;
    armed = 1'b0;
    ALU_OUT = '0;
    ALU_OUT_VALID = 1'b0;
    forever begin
      @(negedge CLK);
      if (ALU_EN) begin
        armed = 1'b1;
        wcnt = 0;
        ALU_OUT_VALID = 1'b0;
      end else begin
        ALU_OUT_VALID = 1'b0;
        ALU_OUT = WIDTH'($urandom);
        if (armed) begin
          wcnt++;
          if (wcnt == alu_delay) begin
            ALU_OUT_VALID = 1'b1;
            ALU_OUT = alu_ref(ALU_A, ALU_B, ALU_FUN);
            armed = 1'b0;
          end else if (wcnt > 2 * TIMEOUT) begin
            armed = 1'b0;
          end
        end
      end
    end
  end

  task automatic rst_chk();
    chk("rst_alu_a", ALU_A, 0);
    chk("rst_alu_b", ALU_B, 0);
    chk("rst_alu_fun", ALU_FUN, 0);
    chk("rst_alu_en", ALU_EN, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
  endtask

  // One full command, entered and left at a negedge with the DUT in IDLE.
  task automatic do_cmd(input logic [NR-1:0] newm, input int delay, input int bp, input bit refill,
                        input logic [NR-1:0] late);
    logic [NR-1:0]    mask;
    int               w, waits, expw;
    bit               exp_err;
    logic [WIDTH-1:0] exp_d;
    mask = pend | newm;
    alu_delay = delay;
    rsp_ready = (bp == 0);
    drive_req(mask);
    #1;
    w = model_pick(mask);
    exp_err = !(delay >= 1 && delay <= TIMEOUT);
    expw = exp_err ? TIMEOUT : delay;
    exp_d = exp_err ? '0 : alu_ref(cmd_a[w], cmd_b[w], cmd_f[w]);
    chk("idle_busy", busy, 0);
    chk("grant", req_ready, 32'(1) << w);
    @(negedge CLK);
    chk("issue_en", ALU_EN, 1);
    chk("issue_alu_a", ALU_A, cmd_a[w]);
    chk("issue_alu_b", ALU_B, cmd_b[w]);
    chk("issue_alu_fun", ALU_FUN, cmd_f[w]);
    chk("issue_busy", busy, 1);
    if (!refill) mask[w] = 1'b0;
    mask |= late;
    drive_req(mask);
    #1;
    chk("issue_rdy", req_ready, 0);
    waits = 0;
    @(negedge CLK);
    while (!rsp_valid && waits <= TIMEOUT + 1) begin
      waits++;
      chk("wait_en", ALU_EN, 0);
      chk("wait_hold_a", ALU_A, cmd_a[w]);
      chk("wait_rdy", req_ready, 0);
      @(negedge CLK);
    end
    chk("wait_cycles", waits, expw);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_id", rsp_id, w);
    chk("rsp_err", rsp_err, exp_err);
    last_id = int'(rsp_id);
    for (int k = 0; k < bp; k++) begin
      @(negedge CLK);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp_d);
      chk("bp_id", rsp_id, w);
      chk("bp_err", rsp_err, exp_err);
      chk("bp_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("resp_done", rsp_valid, 0);
    chk("resp_idle", busy, 0);
    ptr_m = w;
    pend = mask;
  endtask

  task automatic drop_all();
    pend = '0;
    drive_req('0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [NR-1:0] nm, lm;
    for (int i = 0; i < NR; i++) begin
      cmd_a[i] = '0;
      cmd_b[i] = '0;
      cmd_f[i] = '0;
    end
    alu_delay = 1;
    last_id = 0;
    pend = '0;
    rsp_ready = 1'b0;
    RST = 1'b0;
    drive_req('0);
    repeat (2) @(negedge CLK);
    rst_chk();
    RST = 1'b1;
    ptr_m = NR - 1;
    @(negedge CLK);

    // Single CMP-equal request from requester 0.
    cmd_a[0] = 16'd5; cmd_b[0] = 16'd5; cmd_f[0] = 4'd5;
    do_cmd(4'b0001, 1, 0, 1'b0, 4'b0000);
    chk("single_data", rsp_data, 16'd1);

    // Timeout, then a normal command.
    cmd_a[2] = 16'h1234; cmd_b[2] = 16'h0F0F; cmd_f[2] = 4'd2;
    do_cmd(4'b0100, 0, 0, 1'b0, 4'b0000);
    cmd_a[3] = 16'h00FF; cmd_b[3] = 16'h0101; cmd_f[3] = 4'd0;
    do_cmd(4'b1000, 1, 0, 1'b0, 4'b0000);

    // Valid on the last permitted WAIT cycle.
    cmd_a[0] = 16'd1; cmd_b[0] = 16'd2; cmd_f[0] = 4'd0;
    do_cmd(4'b0001, TIMEOUT, 0, 1'b0, 4'b0000);
    chk("coincide_data", rsp_data, 16'd3);
    chk("coincide_err", rsp_err, 0);

    // Backpressure with requester 1 pending throughout.
    cmd_a[0] = 16'hA5A5; cmd_b[0] = 16'h5A5A; cmd_f[0] = 4'd4;
    cmd_a[1] = 16'h0003; cmd_b[1] = 16'h0002; cmd_f[1] = 4'd6;
    do_cmd(4'b0001, 1, 5, 1'b0, 4'b0010);
    do_cmd(4'b0000, 1, 0, 1'b0, 4'b0000);
    chk("bp_next_id", last_id, 1);

    // Reset pulse during WAIT.
    alu_delay = 0;
    drive_req(4'b0100);
    @(negedge CLK);
    drive_req('0);
    repeat (2) @(negedge CLK);
    chk("pre_rst_busy", busy, 1);
    RST = 1'b0;
    drive_req(4'b1111);
    #1;
    rst_chk();
    @(negedge CLK);
    drive_req('0);
    RST = 1'b1;
    ptr_m = NR - 1;
    pend = '0;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_idle", busy, 0);
    end

    // All requesters continuously valid: grants rotate from 0.
    for (int i = 0; i < NR; i++) begin
      cmd_a[i] = WIDTH'(16'h0010 * (i + 1));
      cmd_b[i] = WIDTH'(i);
      cmd_f[i] = 4'd0;
    end
    for (int i = 0; i < 5; i++) begin
      do_cmd(4'b1111, 1, 0, 1'b1, 4'b0000);
      chk("rr_order", last_id, i % NR);
    end
    drop_all();
    @(negedge CLK);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i]) begin
          cmd_a[i] = WIDTH'($urandom);
          cmd_b[i] = WIDTH'($urandom);
          cmd_f[i] = 4'($urandom);
        end
      end
      nm = NR'($urandom);
      lm = NR'($urandom) & NR'($urandom);
      if ((pend | nm) == '0) nm[$urandom_range(0, NR - 1)] = 1'b1;
      do_cmd(nm, int'($urandom_range(0, TIMEOUT)), int'($urandom_range(0, 3)), 1'b0, lm);
    end
    drop_all();
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
